// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the scanned 7-segment display driver.
// The optional blink feature in seg7_scan_display is enabled by defining SEG7_BLINK_EN.
package seg7_pkg;

  // Segment pattern with every segment dark (active-LOW).
  localparam logic [6:0] SEG7_BLANK = 7'h7F;

  // Hex font, active-LOW, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7_font(input logic [3:0] nibble);
    logic [6:0] pattern;
    case (nibble)
      4'h0:    pattern = 7'h40;
      4'h1:    pattern = 7'h79;
      4'h2:    pattern = 7'h24;
      4'h3:    pattern = 7'h30;
      4'h4:    pattern = 7'h19;
      4'h5:    pattern = 7'h12;
      4'h6:    pattern = 7'h02;
      4'h7:    pattern = 7'h78;
      4'h8:    pattern = 7'h00;
      4'h9:    pattern = 7'h10;
      4'hA:    pattern = 7'h08;
      4'hB:    pattern = 7'h03;
      4'hC:    pattern = 7'h46;
      4'hD:    pattern = 7'h21;
      4'hE:    pattern = 7'h06;
      default: pattern = 7'h0E;
    endcase
    return pattern;
  endfunction

  // Width of a counter that runs 0..cycles-1 (at least one bit).
  function automatic int unsigned seg7_cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-LOW 7-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Font lookup of the selected digit.
  always_comb begin
    seg = seg7_font(nibble);
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed N-digit common-anode 7-segment driver with frame-synchronous
// (tear-free) updates and an all-anodes-off guard at the start of each dwell.
// Define SEG7_BLINK_EN to add the per-digit blink input and blink phase logic.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYC    = 100000,
  parameter int unsigned GUARD_CYC    = 500
`ifdef SEG7_BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES = 250
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink,
`endif
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned CNT_W = seg7_cnt_width(DWELL_CYC);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic                    dwell_end;
  logic                    frame_end;

  logic [4*NUM_DIGITS-1:0] shadow_value;
  logic [NUM_DIGITS-1:0]   shadow_blank;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] disp_value;
  logic [NUM_DIGITS-1:0]   disp_blank;
  logic [NUM_DIGITS-1:0]   disp_dp;

  logic [3:0]              nibble;
  logic                    digit_dark;
  logic                    digit_dp;
  logic                    guard;
  logic [6:0]              font_seg;
  logic [6:0]              seg_d;
  logic                    dp_n_d;
  logic [NUM_DIGITS-1:0]   an_d;

`ifdef SEG7_BLINK_EN
  localparam int unsigned FRM_W = seg7_cnt_width(BLINK_FRAMES);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [NUM_DIGITS-1:0]   shadow_blink;
  logic [NUM_DIGITS-1:0]   disp_blink;
  logic [FRM_W-1:0]        frame_cnt;
  logic                    blink_phase;
`endif

  assign dwell_end  = (cnt == CNT_LAST);
  assign frame_end  = dwell_end && (idx == IDX_LAST);
  assign frame_done = frame_end;

  // Dwell counter and digit index scan.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (dwell_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow capture on load; display regs only change on the frame boundary.
  // A load coinciding with the boundary bypasses the shadow straight into display.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_value <= '0;
      shadow_blank <= '1;
      shadow_dp    <= '0;
      pending      <= 1'b0;
      disp_value   <= '0;
      disp_blank   <= '1;
      disp_dp      <= '0;
    end else if (frame_end) begin
      pending <= 1'b0;
      if (load) begin
        disp_value <= value;
        disp_blank <= blank;
        disp_dp    <= dp;
      end else if (pending) begin
        disp_value <= shadow_value;
        disp_blank <= shadow_blank;
        disp_dp    <= shadow_dp;
      end
    end else if (load) begin
      shadow_value <= value;
      shadow_blank <= blank;
      shadow_dp    <= dp;
      pending      <= 1'b1;
    end
  end

`ifdef SEG7_BLINK_EN
  // Blink attribute follows the same shadow/display path; phase flips every BLINK_FRAMES frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_blink <= '0;
      disp_blink   <= '0;
      frame_cnt    <= '0;
      blink_phase  <= 1'b0;
    end else if (frame_end) begin
      if (load) begin
        disp_blink <= blink;
      end else if (pending) begin
        disp_blink <= shadow_blink;
      end
      if (frame_cnt == FRM_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end else if (load) begin
      shadow_blink <= blink;
    end
  end
`endif

  // Select the current digit's nibble and attributes.
  always_comb begin
    nibble     = 4'h0;
    digit_dark = 1'b1;
    digit_dp   = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nibble     = disp_value[4*i +: 4];
`ifdef SEG7_BLINK_EN
        digit_dark = disp_blank[i] | (disp_blink[i] & blink_phase);
`else
        digit_dark = disp_blank[i];
`endif
        digit_dp   = disp_dp[i];
      end
    end
  end

  seg7_hex_decode u_decode (
    .nibble (nibble),
    .seg    (font_seg)
  );

  // Next output values: guard interval first, then the selected digit.
  always_comb begin
    guard  = (32'(cnt) < GUARD_CYC);
    an_d   = '1;
    seg_d  = SEG7_BLANK;
    dp_n_d = 1'b1;
    if (!guard) begin
      an_d = ~(NUM_DIGITS'(1) << idx);
      if (!digit_dark) begin
        seg_d  = font_seg;
        dp_n_d = ~digit_dp;
      end
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg  <= SEG7_BLANK;
      dp_n <= 1'b1;
      an   <= '1;
    end else begin
      seg  <= seg_d;
      dp_n <= dp_n_d;
      an   <= an_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display (4 digits, dwell 4, guard 1).
// Blink scenario runs only when SEG7_BLINK_EN is defined.
module tb_seg7_scan_display;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int G  = 1;
  localparam int BF = 2;
`ifdef SEG7_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
  } out_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   value;
  logic [3:0]    blank;
  logic [3:0]    dp;
  logic          load;
  logic [3:0]    blink;
  logic [6:0]    seg;
  logic          dp_n;
  logic [3:0]    an;
  logic          frame_done;

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  out_t          exp_q[$];

  // spot checks: fixed expected pattern per digit, independent of the model
  bit            spot_en = 1'b0;
  logic [6:0]    spot_seg [4];
  logic          spot_dp  [4];

  // reference model state
  int            m_cnt, m_idx, m_fcnt;
  logic          m_pend, m_phase;
  logic [15:0]   m_sh_val, m_d_val;
  logic [3:0]    m_sh_blank, m_sh_dp, m_sh_blink, m_d_blank, m_d_dp, m_d_blink;

  always #5 clk = ~clk;

  seg7_scan_display #(
    .NUM_DIGITS   (N),
    .DWELL_CYC    (D),
    .GUARD_CYC    (G)
`ifdef SEG7_BLINK_EN
    ,
    .BLINK_FRAMES (BF)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .blank      (blank),
    .dp         (dp),
    .load       (load),
`ifdef SEG7_BLINK_EN
    .blink      (blink),
`endif
    .seg        (seg),
    .dp_n       (dp_n),
    .an         (an),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_fd();
    return (m_cnt == D - 1) && (m_idx == N - 1);
  endfunction

  // Output expected right after the coming clock edge.
  function automatic out_t model_out();
    out_t o;
    logic dark;
    o.an = 4'hF; o.seg = 7'h7F; o.dp_n = 1'b1;
    if (rst_n && m_cnt >= G) begin
      o.an = 4'hF;
      o.an[m_idx] = 1'b0;
      dark = m_d_blank[m_idx] | (BLINK_ON & m_d_blink[m_idx] & m_phase);
      if (!dark) begin
        o.seg  = FONT[m_d_val[4*m_idx +: 4]];
        o.dp_n = ~m_d_dp[m_idx];
      end
    end
    return o;
  endfunction

  task automatic model_update();
    logic fe;
    if (!rst_n) begin
      m_cnt = 0; m_idx = 0; m_fcnt = 0; m_phase = 1'b0; m_pend = 1'b0;
      m_sh_val = '0; m_sh_blank = '1; m_sh_dp = '0; m_sh_blink = '0;
      m_d_val  = '0; m_d_blank  = '1; m_d_dp  = '0; m_d_blink  = '0;
    end else begin
      fe = model_fd();
      if (fe) begin
        if (load) begin
          m_d_val = value; m_d_blank = blank; m_d_dp = dp; m_d_blink = blink;
        end else if (m_pend) begin
          m_d_val = m_sh_val; m_d_blank = m_sh_blank; m_d_dp = m_sh_dp; m_d_blink = m_sh_blink;
        end
        m_pend = 1'b0;
        if (m_fcnt == BF - 1) begin
          m_fcnt = 0; m_phase = ~m_phase;
        end else begin
          m_fcnt++;
        end
      end else if (load) begin
        m_sh_val = value; m_sh_blank = blank; m_sh_dp = dp; m_sh_blink = blink;
        m_pend = 1'b1;
      end
      if (m_cnt == D - 1) begin
        m_cnt = 0;
        m_idx = (m_idx == N - 1) ? 0 : m_idx + 1;
      end else begin
        m_cnt++;
      end
    end
  endtask

  // One clock: inputs are already set; push the expectation, clock, pop and compare.
  task automatic step();
    out_t e;
    e = model_out();
    @(negedge clk);
    check("frame_done", 32'(frame_done), 32'(model_fd()));
    exp_q.push_back(e);
    model_update();
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("an", 32'(an), 32'(e.an));
      check("seg", 32'(seg), 32'(e.seg));
      check("dp_n", 32'(dp_n), 32'(e.dp_n));
      if (spot_en && e.an != 4'hF) begin
        for (int d = 0; d < N; d++) begin
          if (e.an == ~(4'b0001 << d)) begin
            check($sformatf("spot_seg%0d", d), 32'(seg), 32'(spot_seg[d]));
            check($sformatf("spot_dp%0d", d), 32'(dp_n), 32'(spot_dp[d]));
          end
        end
      end
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Step through the next frame boundary cycle (bounded).
  task automatic run_to_boundary();
    logic fd;
    for (int k = 0; k < 4 * N * D; k++) begin
      fd = model_fd();
      step();
      if (fd) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL boundary_timeout: no frame boundary within %0d cycles", 4 * N * D);
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] b, input logic [3:0] p, input logic [3:0] bl);
    value = v; blank = b; dp = p; blink = bl; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic set_spot(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                          input logic [6:0] s0, input logic [3:0] dpn);
    spot_seg[3] = s3; spot_seg[2] = s2; spot_seg[1] = s1; spot_seg[0] = s0;
    for (int d = 0; d < N; d++) spot_dp[d] = dpn[d];
  endtask

  initial begin
    rst_n = 1'b0; value = '0; blank = '0; dp = '0; load = 1'b0; blink = '0;
    model_update();
    @(posedge clk);
    #1;

    // 1: reset held 3 cycles, then dark with no load
    steps(3);
    check("rst_an", 32'(an), 32'h0F);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp_n", 32'(dp_n), 32'h1);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    rst_n = 1'b1;
    set_spot(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b1111);
    spot_en = 1'b1;
    steps(20);

    // 2: load 1234 with dp on digit 1, observe two full frames
    spot_en = 1'b0;
    pulse_load(16'h1234, 4'b0000, 4'b0010, 4'b0000);
    run_to_boundary();
    set_spot(7'h79, 7'h24, 7'h30, 7'h19, 4'b1101);
    spot_en = 1'b1;
    steps(2 * N * D);

    // 3: mid-frame load does not tear the current frame
    steps(5);
    pulse_load(16'hABCD, 4'b0000, 4'b0010, 4'b0000);
    run_to_boundary();
    set_spot(7'h08, 7'h03, 7'h46, 7'h21, 4'b1101);
    steps(N * D);

    // 4: last of two loads wins; load on the boundary cycle applies to the new frame
    steps(2);
    pulse_load(16'h5555, 4'b0000, 4'b0000, 4'b0000);
    steps(3);
    pulse_load(16'h6666, 4'b0000, 4'b0000, 4'b0000);
    spot_en = 1'b0;
    run_to_boundary();
    set_spot(7'h02, 7'h02, 7'h02, 7'h02, 4'b1111);
    spot_en = 1'b1;
    steps(N * D - 1);
    check("fd_before_boundary_load", 32'(model_fd()), 32'h1);
    pulse_load(16'h7777, 4'b0000, 4'b0000, 4'b0000);
    set_spot(7'h78, 7'h78, 7'h78, 7'h78, 4'b1111);
    steps(N * D);

    // 5: blank digit 3, then reset in the middle of a dwell
    pulse_load(16'h1234, 4'b1000, 4'b0010, 4'b0000);
    spot_en = 1'b0;
    run_to_boundary();
    set_spot(7'h7F, 7'h24, 7'h30, 7'h19, 4'b1101);
    spot_en = 1'b1;
    steps(N * D + 6);
    spot_en = 1'b0;
    pulse_load(16'h4321, 4'b0000, 4'b0000, 4'b0000);
    rst_n = 1'b0;
    step();
    check("midrst_an", 32'(an), 32'h0F);
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_dp_n", 32'(dp_n), 32'h1);
    rst_n = 1'b1;
    set_spot(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b1111);
    spot_en = 1'b1;
    steps(2 * N * D);

`ifdef SEG7_BLINK_EN
    // 6: digit 0 blinks with a 2-frame half period
    spot_en = 1'b0;
    pulse_load(16'h1234, 4'b0000, 4'b0000, 4'b0001);
    run_to_boundary();
    steps(6 * N * D);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
